// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue
// Brief    : WISC decode/issue stage. Splits the instruction fields, reads the
//            8x16 register file with writeback bypass, tracks RAW/WAW hazards
//            with a per-register scoreboard, and issues into a one-entry
//            output register.
// Revision : 1.0
// ============================================================================
module decode_issue #(
    parameter int          NREGS  = 8,
    parameter logic [15:0] RST_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_opcode,
    output logic [1:0]  ex_funct,
    output logic [15:0] ex_rs_val,
    output logic [15:0] ex_rt_val,
    output logic [15:0] ex_pc,
    output logic [7:0]  ex_imm,
    output logic [2:0]  ex_rd,
    output logic        ex_wr_en,
    input  logic        wb_en,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic        halted
);

    localparam logic [4:0] c_op_halt = 5'b00000;

    logic [15:0]      r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic             r_halted;

    logic             r_ex_valid;
    logic [4:0]       r_ex_opcode;
    logic [1:0]       r_ex_funct;
    logic [15:0]      r_ex_rs_val;
    logic [15:0]      r_ex_rt_val;
    logic [15:0]      r_ex_pc;
    logic [7:0]       r_ex_imm;
    logic [2:0]       r_ex_rd;
    logic             r_ex_wr_en;

    logic [4:0]       w_opcode;
    logic [2:0]       w_rs_idx;
    logic [2:0]       w_rt_idx;
    logic             w_use_rs;
    logic             w_use_rt;
    logic             w_use_dst;
    logic [2:0]       w_dst_idx;
    logic [15:0]      w_rs_val;
    logic [15:0]      w_rt_val;
    logic [NREGS-1:0] w_wb_hit;
    logic [NREGS-1:0] w_eff_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic             w_hazard;
    logic             w_accept;

    assign w_opcode = in_instr[15:11];
    assign w_rs_idx = in_instr[10:8];
    assign w_rt_idx = in_instr[7:5];

    // Source/destination usage per opcode class; unknown opcodes pass through hazard-free.
    always_comb begin
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_use_dst = 1'b0;
        w_dst_idx = 3'd0;
        casez (w_opcode)
            5'b00101: w_use_rs = 1'b1;
            5'b00110: begin
                w_use_dst = 1'b1;
                w_dst_idx = 3'd7;
            end
            5'b00111: begin
                w_use_rs  = 1'b1;
                w_use_dst = 1'b1;
                w_dst_idx = 3'd7;
            end
            5'b010??, 5'b101??, 5'b10001: begin
                w_use_rs  = 1'b1;
                w_use_dst = 1'b1;
                w_dst_idx = in_instr[7:5];
            end
            5'b011??: w_use_rs = 1'b1;
            5'b10000: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            5'b10010: begin
                w_use_rs  = 1'b1;
                w_use_dst = 1'b1;
                w_dst_idx = in_instr[10:8];
            end
            5'b10011: begin
                w_use_rs  = 1'b1;
                w_use_rt  = 1'b1;
                w_use_dst = 1'b1;
                w_dst_idx = in_instr[10:8];
            end
            5'b11000: begin
                w_use_dst = 1'b1;
                w_dst_idx = in_instr[10:8];
            end
            5'b11001: begin
                w_use_rs  = 1'b1;
                w_use_dst = 1'b1;
                w_dst_idx = in_instr[4:2];
            end
            5'b11010, 5'b11011, 5'b111??: begin
                w_use_rs  = 1'b1;
                w_use_rt  = 1'b1;
                w_use_dst = 1'b1;
                w_dst_idx = in_instr[4:2];
            end
            default: ;
        endcase
    end

    assign w_rs_val = (wb_en && (wb_rd == w_rs_idx)) ? wb_data : r_regs[w_rs_idx];
    assign w_rt_val = (wb_en && (wb_rd == w_rt_idx)) ? wb_data : r_regs[w_rt_idx];

    always_comb begin
        w_wb_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_wb_hit[i] = wb_en && (int'(wb_rd) == i);
        end
    end

    // A writeback landing this cycle already satisfies its waiter.
    assign w_eff_pend = r_pend & ~w_wb_hit;

    assign w_hazard = (w_use_rs  && w_eff_pend[w_rs_idx]) ||
                      (w_use_rt  && w_eff_pend[w_rt_idx]) ||
                      (w_use_dst && w_eff_pend[w_dst_idx]);

    assign in_ready = !r_halted && (!r_ex_valid || ex_ready) && !(in_valid && w_hazard);
    assign w_accept = in_valid && in_ready;

    // Setting by a new issue overrides a same-cycle retire of that register.
    always_comb begin
        w_pend_nxt = w_eff_pend;
        if (w_accept && w_use_dst) begin
            w_pend_nxt[w_dst_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_pend   <= '0;
            r_halted <= 1'b0;
        end else begin
            if (wb_en) begin
                r_regs[wb_rd] <= wb_data;
            end
            r_pend <= w_pend_nxt;
            if (w_accept && (w_opcode == c_op_halt)) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= 5'd0;
            r_ex_funct  <= 2'd0;
            r_ex_rs_val <= 16'h0000;
            r_ex_rt_val <= 16'h0000;
            r_ex_pc     <= RST_PC;
            r_ex_imm    <= 8'h00;
            r_ex_rd     <= 3'd0;
            r_ex_wr_en  <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid  <= 1'b1;
            r_ex_opcode <= w_opcode;
            r_ex_funct  <= in_instr[1:0];
            r_ex_rs_val <= w_rs_val;
            r_ex_rt_val <= w_rt_val;
            r_ex_pc     <= in_pc;
            r_ex_imm    <= in_instr[7:0];
            r_ex_rd     <= w_dst_idx;
            r_ex_wr_en  <= w_use_dst;
        end else if (ex_ready) begin
            r_ex_valid  <= 1'b0;
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_opcode = r_ex_opcode;
    assign ex_funct  = r_ex_funct;
    assign ex_rs_val = r_ex_rs_val;
    assign ex_rt_val = r_ex_rt_val;
    assign ex_pc     = r_ex_pc;
    assign ex_imm    = r_ex_imm;
    assign ex_rd     = r_ex_rd;
    assign ex_wr_en  = r_ex_wr_en;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue
// Brief    : Directed and randomized bench for decode_issue against an
//            instruction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_decode_issue;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_funct;
    logic [15:0] ex_rs_val;
    logic [15:0] ex_rt_val;
    logic [15:0] ex_pc;
    logic [7:0]  ex_imm;
    logic [2:0]  ex_rd;
    logic        ex_wr_en;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        halted;

    decode_issue #(.NREGS(8), .RST_PC(RST_PC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [1:0]  funct;
        logic [15:0] rs_val;
        logic [15:0] rt_val;
        logic [15:0] pc;
        logic [7:0]  imm;
        logic [2:0]  rd;
        logic        wr_en;
    } ex_t;

    logic [15:0] m_regs [8];
    logic [7:0]  m_pend;
    logic        m_halted;
    ex_t         m_ex;

    int   n_checks = 0;
    int   n_errors = 0;
    logic last_ready;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level view of which registers an opcode reads and writes.
    function automatic void ref_decode(input logic [15:0] ins, output logic rs_src,
                                       output logic rt_src, output logic has_dst, output int dst);
        int op;
        op      = int'(ins[15:11]);
        rs_src  = op inside {5, 7, [8:23], [25:31]};
        rt_src  = op inside {16, 19, [26:31]};
        has_dst = 1'b1;
        if (op inside {6, 7})                    dst = 7;
        else if (op inside {[8:11], [20:23], 17}) dst = int'(ins[7:5]);
        else if (op inside {18, 19, 24})          dst = int'(ins[10:8]);
        else if (op inside {[25:31]})             dst = int'(ins[4:2]);
        else begin
            has_dst = 1'b0;
            dst     = 0;
        end
    endfunction

    function automatic logic still_pending(input int r);
        return m_pend[r] && !(wb_en && int'(wb_rd) == r);
    endfunction

    function automatic logic [15:0] read_reg(input int r);
        return (wb_en && int'(wb_rd) == r) ? wb_data : m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_pend   = 8'h00;
        m_halted = 1'b0;
        m_ex     = '0;
        m_ex.pc  = RST_PC;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".ex_valid"},  ex_valid,  m_ex.valid);
        check_val({tag, ".halted"},    halted,    m_halted);
        check_val({tag, ".ex_opcode"}, ex_opcode, m_ex.op);
        check_val({tag, ".ex_funct"},  ex_funct,  m_ex.funct);
        check_val({tag, ".ex_rs_val"}, ex_rs_val, m_ex.rs_val);
        check_val({tag, ".ex_rt_val"}, ex_rt_val, m_ex.rt_val);
        check_val({tag, ".ex_pc"},     ex_pc,     m_ex.pc);
        check_val({tag, ".ex_imm"},    ex_imm,    m_ex.imm);
        check_val({tag, ".ex_rd"},     ex_rd,     m_ex.rd);
        check_val({tag, ".ex_wr_en"},  ex_wr_en,  m_ex.wr_en);
    endtask

    // One clock: drive at negedge, check ready, advance the model, check at posedge+1.
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic er, input logic we, input logic [2:0] wr, input logic [15:0] wd);
        logic rs_s, rt_s, hd, haz, exp_rdy, acc;
        int   dst, rs, rt;
        ex_t  nx;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc;
        ex_ready = er; wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        ref_decode(ins, rs_s, rt_s, hd, dst);
        rs  = int'(ins[10:8]);
        rt  = int'(ins[7:5]);
        haz = (rs_s && still_pending(rs)) || (rt_s && still_pending(rt)) || (hd && still_pending(dst));
        exp_rdy = !m_halted && (!m_ex.valid || er) && !(v && haz);
        last_ready = in_ready;
        check_val("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        nx  = m_ex;
        if (acc) begin
            nx.valid  = 1'b1;
            nx.op     = ins[15:11];
            nx.funct  = ins[1:0];
            nx.rs_val = read_reg(rs);
            nx.rt_val = read_reg(rt);
            nx.pc     = pc;
            nx.imm    = ins[7:0];
            nx.rd     = hd ? 3'(dst) : 3'd0;
            nx.wr_en  = hd;
            if (ins[15:11] == 5'd0) m_halted = 1'b1;
        end else if (er) begin
            nx.valid = 1'b0;
        end
        m_ex = nx;
        if (we) begin
            m_regs[wr] = wd;
            m_pend[wr] = 1'b0;
        end
        if (acc && hd) m_pend[dst] = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; wb_en = 1'b0; ex_ready = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        check_val("rst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic        r_v, r_er, r_we;
    logic [15:0] r_ins;
    logic [2:0]  r_wr;
    int          pq[$];

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0;
        ex_ready = 1'b0; wb_en = 1'b0; wb_rd = 3'd0; wb_data = 16'h0;
        model_reset();
        do_reset();

        // ADDI R2,R1,#3 after R1 is written
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h1234);
        step(1'b1, 16'h4143, 16'h0010, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t1.opcode", ex_opcode, 5'b01000);
        check_val("t1.rs_val", ex_rs_val, 16'h1234);
        check_val("t1.rd",     ex_rd,     3'd2);
        check_val("t1.wr_en",  ex_wr_en,  1'b1);
        check_val("t1.imm",    ex_imm,    8'h43);

        // ADD R3,R2,R2 stalls on R2 until writeback, bypassing its value
        step(1'b1, 16'hDA4C, 16'h0012, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t2.stall", last_ready, 1'b0);
        step(1'b1, 16'hDA4C, 16'h0012, 1'b1, 1'b0, 3'd0, 16'h0000);
        step(1'b1, 16'hDA4C, 16'h0012, 1'b1, 1'b1, 3'd2, 16'hBEEF);
        check_val("t2.issue", last_ready, 1'b1);
        check_val("t2.rs_val", ex_rs_val, 16'hBEEF);
        check_val("t2.rt_val", ex_rt_val, 16'hBEEF);

        // Output back-pressure holds the register and blocks intake
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0800, 16'h0014, 1'b0, 1'b0, 3'd0, 16'h0000);
            check_val("t3.blocked", last_ready, 1'b0);
            check_val("t3.hold", ex_rs_val, 16'hBEEF);
        end
        step(1'b1, 16'h0800, 16'h0014, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t3.opcode", ex_opcode, 5'b00001);
        check_val("t3.pc", ex_pc, 16'h0014);

        // Same-cycle retire and re-issue of R4 leaves it pending
        step(1'b1, 16'hC480, 16'h0016, 1'b1, 1'b1, 3'd3, 16'h3333);
        step(1'b1, 16'hC401, 16'h0018, 1'b1, 1'b1, 3'd4, 16'h5555);
        check_val("t4.reissue", last_ready, 1'b1);
        step(1'b1, 16'hDC04, 16'h001A, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t4.stall", last_ready, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd4, 16'h4444);

        // JALR writes R7; a reader of R7 waits for its writeback
        step(1'b1, 16'h3D00, 16'h0020, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t6.rd", ex_rd, 3'd7);
        check_val("t6.wr_en", ex_wr_en, 1'b1);
        step(1'b1, 16'hDF04, 16'h0022, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t6.stall", last_ready, 1'b0);
        step(1'b1, 16'hDF04, 16'h0022, 1'b1, 1'b1, 3'd7, 16'h7777);
        check_val("t6.rs_val", ex_rs_val, 16'h7777);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h1111);

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            r_v   = ($urandom_range(0, 9) < 8);
            r_er  = ($urandom_range(0, 9) < 7);
            r_we  = ($urandom_range(0, 1) == 1);
            r_ins = {5'($urandom_range(1, 31)), 11'($urandom)};
            pq.delete();
            for (int i = 0; i < 8; i++) if (m_pend[i]) pq.push_back(i);
            if (pq.size() > 0 && $urandom_range(0, 3) != 0)
                r_wr = 3'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                r_wr = 3'($urandom_range(0, 7));
            step(r_v, r_ins, 16'($urandom), r_er, r_we, r_wr, 16'($urandom));
        end

        // HALT is sticky until reset
        step(1'b1, 16'h0000, 16'h0030, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t5.halted", halted, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0800, 16'h0032, 1'b1, 1'b0, 3'd0, 16'h0000);
            check_val("t5.blocked", last_ready, 1'b0);
        end
        do_reset();
        check_val("t5.cleared", halted, 1'b0);
        step(1'b1, 16'hD94C, 16'h0040, 1'b1, 1'b0, 3'd0, 16'h0000);
        check_val("t5.r1_zero", ex_rs_val, 16'h0000);
        check_val("t5.r2_zero", ex_rt_val, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
